// File: rtl/cdc_channel_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : cdc_ctl_pkg
// Brief   : Shared state encoding and helpers for the CDC channel arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package cdc_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETUP    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_channel_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : cdc_channel_arbiter_if
// Brief     : Requester bus plus synchronizer channel signals of the arbiter.
// Rev       : 1.0  initial release
// ============================================================================
interface cdc_channel_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid_i;
    logic [NREQ*WIDTH-1:0] req_data_i;
    logic [NREQ-1:0]       req_ready_o;
    logic [WIDTH-1:0]      ch_data_o;
    logic [IDW-1:0]        ch_id_o;
    logic                  ch_toggle_o;
    logic                  ch_ack_i;
    logic                  busy_o;
    logic                  timeout_o;

    // Environment side: requesters and the destination acknowledge.
    modport master (
        output req_valid_i, req_data_i, ch_ack_i,
        input  req_ready_o, ch_data_o, ch_id_o, ch_toggle_o, busy_o, timeout_o
    );

    // Arbiter side.
    modport slave (
        input  req_valid_i, req_data_i, ch_ack_i,
        output req_ready_o, ch_data_o, ch_id_o, ch_toggle_o, busy_o, timeout_o
    );

endinterface
`default_nettype wire

// File: rtl/cdc_channel_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick: first valid index above last.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  wire logic [NREQ-1:0]         valid_i,
    input  wire logic [$clog2(NREQ)-1:0] last_i,
    output logic      [NREQ-1:0]         grant_o,
    output logic      [$clog2(NREQ)-1:0] idx_o,
    output logic                         any_o
);
    localparam int IDW = $clog2(NREQ);

    int   w_pos;
    logic w_found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        // Offsets 1..NREQ wrap back to last itself, so last is lowest priority.
        for (int k = 1; k <= NREQ; k++) begin
            w_pos = (int'(last_i) + k) % NREQ;
            if (!w_found && valid_i[w_pos[IDW-1:0]]) begin
                w_found                 = 1'b1;
                grant_o[w_pos[IDW-1:0]] = 1'b1;
                idx_o                   = w_pos[IDW-1:0];
            end
        end
    end

    assign any_o = |valid_i;

endmodule
`default_nettype wire

// File: rtl/cdc_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module : cdc_channel_arbiter
// Brief  : Shares one toggle-handshake synchronizer channel among requesters.
// Rev    : 1.0  initial release
// ============================================================================
module cdc_channel_arbiter #(
    parameter int NREQ           = 4,
    parameter int WIDTH          = 8,
    parameter int SETUP_CYCLES   = 6,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic             clk,
    input  wire logic             rst,
    cdc_channel_arbiter_if.slave  bus
);
    import cdc_ctl_pkg::*;

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(max_int(SETUP_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] ch_data_q;
    logic [IDW-1:0]   ch_id_q;
    logic             toggle_q;
    logic             busy_q;
    logic             timeout_q;
    logic [IDW-1:0]   last_q;

    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_idx;
    logic             w_any;
    logic [WIDTH-1:0] w_word;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .valid_i (bus.req_valid_i),
        .last_i  (last_q),
        .grant_o (w_grant),
        .idx_o   (w_idx),
        .any_o   (w_any)
    );

    always_comb begin
        w_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_idx == IDW'(i)) begin
                w_word = bus.req_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ch_data_q <= '0;
            ch_id_q   <= '0;
            toggle_q  <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            last_q    <= IDW'(NREQ - 1);
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_any) begin
                        ch_data_q <= w_word;
                        ch_id_q   <= w_idx;
                        last_q    <= w_idx;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    // Word has been stable for the full setup window by this edge.
                    if (cnt_q == SETUP_LAST) begin
                        toggle_q <= ~toggle_q;
                        cnt_q    <= '0;
                        state_q  <= ST_WAIT_ACK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (bus.ch_ack_i == toggle_q) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o = (state_q == ST_IDLE) ? w_grant : '0;
    assign bus.ch_data_o   = ch_data_q;
    assign bus.ch_id_o     = ch_id_q;
    assign bus.ch_toggle_o = toggle_q;
    assign bus.busy_o      = busy_q;
    assign bus.timeout_o   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_cdc_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_cdc_channel_arbiter
// Brief  : Directed plus randomized bench with a cycle-timestamp reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cdc_channel_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int S     = 3;
    localparam int T     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cdc_channel_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    cdc_channel_arbiter #(
        .NREQ           (NREQ),
        .WIDTH          (WIDTH),
        .SETUP_CYCLES   (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: transfers described by their grant timestamp.
    bit               m_init = 0;
    logic             m_busy;
    int               m_t0;
    logic [WIDTH-1:0] m_data;
    int               m_id;
    logic             m_tog;
    int               m_last;
    logic             m_to;
    int               ncyc = 0;

    always @(negedge clk) begin
        logic [NREQ-1:0] er;
        int eg;
        int p;
        int age;
        er = '0;
        eg = -1;
        if (!m_busy || !m_init) begin
            for (int k = 1; k <= NREQ; k++) begin
                p = (m_last + k) % NREQ;
                if (eg < 0 && bus.req_valid_i[p]) eg = p;
            end
        end
        if (eg >= 0) er[eg] = 1'b1;

        if (m_init) begin
            chk("ready",   bus.req_ready_o, er);
            chk("data",    bus.ch_data_o, m_data);
            chk("id",      bus.ch_id_o, 32'(m_id));
            chk("toggle",  bus.ch_toggle_o, m_tog);
            chk("busy",    bus.busy_o, m_busy);
            chk("timeout", bus.timeout_o, m_to);
        end

        if (rst) begin
            m_init = 1;
            m_busy = 0;
            m_data = '0;
            m_id   = 0;
            m_tog  = 0;
            m_last = NREQ - 1;
            m_to   = 0;
        end else if (m_init) begin
            m_to = 0;
            if (!m_busy) begin
                if (eg >= 0) begin
                    m_data = bus.req_data_i[eg*WIDTH +: WIDTH];
                    m_id   = eg;
                    m_last = eg;
                    m_busy = 1;
                    m_t0   = ncyc;
                end
            end else begin
                age = ncyc - m_t0;
                if (age == S) begin
                    m_tog = ~m_tog;
                end else if (age > S) begin
                    if (bus.ch_ack_i == m_tog) m_busy = 0;
                    else if (age - S - 1 == T - 1) begin
                        m_to   = 1;
                        m_busy = 0;
                    end
                end
            end
        end
        ncyc++;
    end

    // Stimulus side: destination acknowledge responder and cycle stepping.
    logic [NREQ-1:0] g_rdy;
    bit   auto_ack    = 0;
    int   fixed_delay = -1;
    int   ack_cnt     = -1;
    logic tog_seen    = 1'b0;
    int   cyc_main    = 0;

    task automatic step();
        @(negedge clk);
        g_rdy = bus.req_ready_o;
        @(posedge clk);
        #1;
        cyc_main++;
        if (rst) begin
            tog_seen = 1'b0;
            ack_cnt  = -1;
        end else if (auto_ack) begin
            if (bus.ch_toggle_o != tog_seen) begin
                tog_seen = bus.ch_toggle_o;
                if (fixed_delay >= 0) ack_cnt = fixed_delay;
                else if ($urandom_range(0, 9) == 0) ack_cnt = -1;
                else ack_cnt = int'($urandom_range(0, 6));
            end
            if (ack_cnt == 0) begin
                bus.ch_ack_i = tog_seen;
                ack_cnt = -1;
            end else if (ack_cnt > 0) begin
                ack_cnt--;
            end
        end
    endtask

    initial begin
        int k;
        int got;
        int drop_wait;
        int order [7];
        int gtime [7];
        int exp_order [7];
        exp_order = '{0, 1, 2, 3, 0, 1, 3};

        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        bus.ch_ack_i    = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        chk("rst_ready",   bus.req_ready_o, 0);
        chk("rst_data",    bus.ch_data_o, 0);
        chk("rst_id",      bus.ch_id_o, 0);
        chk("rst_toggle",  bus.ch_toggle_o, 0);
        chk("rst_busy",    bus.busy_o, 0);
        chk("rst_timeout", bus.timeout_o, 0);
        rst = 1'b0;

        // Single transfer from requester 0.
        bus.req_valid_i = 4'b0001;
        bus.req_data_i[7:0] = 8'hA5;
        step();
        chk("grant0_ready", g_rdy, 4'b0001);
        bus.req_valid_i = '0;
        chk("grant0_data", bus.ch_data_o, 8'hA5);
        chk("grant0_id",   bus.ch_id_o, 0);
        chk("grant0_busy", bus.busy_o, 1);
        repeat (S - 1) step();
        chk("toggle_held", bus.ch_toggle_o, 0);
        step();
        chk("toggle_flip", bus.ch_toggle_o, 1);
        bus.ch_ack_i = 1'b1;
        step();
        step();
        chk("ack_idle", bus.busy_o, 0);

        // Unanswered transfer from requester 1 times out.
        bus.req_valid_i = 4'b0010;
        bus.req_data_i[15:8] = 8'h5A;
        step();
        chk("grant1_ready", g_rdy, 4'b0010);
        bus.req_valid_i = '0;
        repeat (S) step();
        chk("toggle_back", bus.ch_toggle_o, 0);
        k = 0;
        while (k < 3 * T && !bus.timeout_o) begin
            step();
            k++;
        end
        chk("timeout_latency", k, T);
        chk("timeout_busy", bus.busy_o, 0);
        step();
        chk("timeout_pulse_width", bus.timeout_o, 0);

        // Stale ack matches the next flip and is accepted at once.
        bus.req_valid_i = 4'b0100;
        bus.req_data_i[23:16] = 8'hC3;
        step();
        bus.req_valid_i = '0;
        repeat (S) step();
        chk("stale_toggle", bus.ch_toggle_o, 1);
        step();
        chk("stale_ack_accepted", bus.busy_o, 0);

        // Reset in WAIT_ACK.
        bus.req_valid_i = 4'b0010;
        bus.req_data_i[15:8] = 8'h3C;
        step();
        bus.req_valid_i = '0;
        repeat (S + 1) step();
        chk("wait_data", bus.ch_data_o, 8'h3C);
        chk("wait_busy", bus.busy_o, 1);
        rst = 1'b1;
        bus.ch_ack_i = 1'b0;
        step();
        rst = 1'b0;
        chk("midrst_data",   bus.ch_data_o, 0);
        chk("midrst_toggle", bus.ch_toggle_o, 0);
        chk("midrst_busy",   bus.busy_o, 0);
        chk("midrst_id",     bus.ch_id_o, 0);

        // Round robin with immediate ack; requester 2 drops before its turn.
        auto_ack    = 1;
        fixed_delay = 0;
        tog_seen    = bus.ch_toggle_o;
        ack_cnt     = -1;
        for (int i = 0; i < NREQ; i++) bus.req_data_i[i*WIDTH +: WIDTH] = WIDTH'(8'h10 + i);
        bus.req_valid_i = 4'b1111;
        got = 0;
        drop_wait = 0;
        for (int c = 0; c < 200 && got < 7; c++) begin
            step();
            if (drop_wait > 0) begin
                drop_wait--;
                if (drop_wait == 0) bus.req_valid_i[2] = 1'b0;
            end
            if (g_rdy != '0) begin
                k = onehot_idx(g_rdy);
                order[got] = k;
                gtime[got] = cyc_main;
                got++;
                bus.req_data_i[k*WIDTH +: WIDTH] = WIDTH'($urandom);
                if (got == 6) drop_wait = S;
            end
        end
        chk("rr_grant_count", got, 7);
        for (int i = 0; i < 7; i++) begin
            if (i < got) chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);
        end
        if (got >= 2) chk("min_period", gtime[1] - gtime[0], S + 2);
        bus.req_valid_i = '0;

        // Randomized traffic, random ack latency, occasional lost acks and resets.
        fixed_delay = -1;
        for (int c = 0; c < 3000; c++) begin
            step();
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                bus.ch_ack_i = 1'b0;
            end else begin
                rst = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (g_rdy[i]) begin
                    bus.req_valid_i[i] = 1'b0;
                end else if (bus.req_valid_i[i]) begin
                    if ($urandom_range(0, 15) == 0) bus.req_valid_i[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.req_valid_i[i] = 1'b1;
                    bus.req_data_i[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
        end
        rst = 1'b0;
        bus.req_valid_i = '0;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
